// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div_pkg
//  Purpose  : Shared types and defaults for the sequential restoring divider.
//  Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

    // Controller states: load in IDLE, alternate SHIFT/SUB per quotient bit,
    // then hold the result in DONE until Run is released.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SUB   = 2'd2,
        DONE  = 2'd3
    } div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 8;

endpackage
`default_nettype wire

// File: rtl/seq_divider_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_divider_if
//  Purpose  : Run/Reset level-handshake bundle shared by the divider and its
//             switch/LED harness (operands in, result and status out).
//  Revision : 1.0 - initial release
// ============================================================================
interface seq_divider_if #(
    parameter int WIDTH = div_pkg::DIV_WIDTH_DEFAULT
);
    logic             Run;
    logic [WIDTH-1:0] Dividend;
    logic [WIDTH-1:0] Divisor;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             Busy;
    logic             Done;
    logic             DivByZero;

    // Harness side: drives the request and operands, observes the result.
    modport master (
        output Run, Dividend, Divisor,
        input  Quotient, Remainder, Busy, Done, DivByZero
    );

    // Divider side.
    modport slave (
        input  Run, Dividend, Divisor,
        output Quotient, Remainder, Busy, Done, DivByZero
    );
endinterface
`default_nettype wire

// File: rtl/seq_divider_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seq_divider_ctrl
//  Purpose  : Sequencing FSM and iteration counter for the restoring divider.
//             Emits one-cycle datapath strobes (load, shift, subtract,
//             commit) plus the Busy/Done status levels.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_divider_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  wire              Clk,
    input  wire              Reset,
    input  wire              i_run,
    input  wire              i_dbz,
    input  wire              i_last,
    output logic             o_ld,
    output logic             o_shift,
    output logic             o_sub_en,
    output logic             o_commit,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

    div_state_t       r_state;
    div_state_t       w_state_next;
    logic [CNT_W-1:0] r_count;

    // State register; Reset wins over every other input.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Quotient-bit counter: cleared on load, advanced once per SUB cycle.
    always_ff @(posedge Clk) begin
        if (Reset || o_ld) begin
            r_count <= '0;
        end else if (o_sub_en) begin
            r_count <= r_count + c_ONE;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        w_state_next = r_state;
        o_ld         = 1'b0;
        o_shift      = 1'b0;
        o_sub_en     = 1'b0;
        o_commit     = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_run) begin
                    o_ld         = 1'b1;
                    // A zero divisor is resolved entirely on the load edge.
                    w_state_next = i_dbz ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                o_busy       = 1'b1;
                o_shift      = 1'b1;
                w_state_next = SUB;
            end
            SUB: begin
                o_busy   = 1'b1;
                o_sub_en = 1'b1;
                if (i_last) begin
                    o_commit     = 1'b1;
                    w_state_next = DONE;
                end else begin
                    w_state_next = SHIFT;
                end
            end
            DONE: begin
                o_done = 1'b1;
                // Run is a level: a new operation needs Run to drop first.
                if (!i_run) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : seq_divider
//  Purpose  : Sequential unsigned restoring divider. Latches the operands on
//             Run, produces one quotient bit per SHIFT/SUB pair and exposes
//             Quotient/Remainder/DivByZero through registered outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  wire          Clk,
    input  wire          Reset,
    seq_divider_if.slave bus
);

    localparam int               c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    // Datapath: A is one bit wider than B so the shifted partial remainder
    // (always < 2*B) never overflows.
    logic [WIDTH:0]       r_a;
    logic [WIDTH-1:0]     r_q;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_quot;
    logic [WIDTH-1:0]     r_rem;
    logic                 r_dbz;

    logic [WIDTH:0]       w_diff;
    logic [WIDTH:0]       w_a_sub;
    logic [WIDTH-1:0]     w_q_sub;
    logic                 w_ld;
    logic                 w_shift;
    logic                 w_sub_en;
    logic                 w_commit;
    logic                 w_busy;
    logic                 w_done;
    logic                 w_dbz;
    logic                 w_last;
    logic [c_CNT_W-1:0]   w_count;

    assign w_dbz  = (bus.Divisor == '0);
    assign w_last = (w_count == c_LAST);

    seq_divider_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (c_CNT_W)
    ) u_ctrl (
        .Clk      (Clk),
        .Reset    (Reset),
        .i_run    (bus.Run),
        .i_dbz    (w_dbz),
        .i_last   (w_last),
        .o_ld     (w_ld),
        .o_shift  (w_shift),
        .o_sub_en (w_sub_en),
        .o_commit (w_commit),
        .o_busy   (w_busy),
        .o_done   (w_done),
        .o_count  (w_count)
    );

    // Trial subtraction; a set MSB means B did not fit, so A is restored.
    always_comb begin
        w_diff  = r_a - {1'b0, r_b};
        w_a_sub = w_diff[WIDTH] ? r_a : w_diff;
        w_q_sub = {r_q[WIDTH-1:1], ~w_diff[WIDTH]};
    end

    // Working registers A/Q/B: load, shift left as a pair, or take the SUB result.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_a <= '0;
            r_q <= '0;
            r_b <= '0;
        end else if (w_ld) begin
            r_a <= '0;
            r_q <= bus.Dividend;
            r_b <= bus.Divisor;
        end else if (w_shift) begin
            {r_a, r_q} <= {r_a[WIDTH-1:0], r_q, 1'b0};
        end else if (w_sub_en) begin
            r_a <= w_a_sub;
            r_q <= w_q_sub;
        end
    end

    // Result registers change only on the final SUB edge or a zero-divisor load,
    // so the previous result stays visible through IDLE and during a new run.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
        end else if (w_ld) begin
            r_dbz <= w_dbz;
            if (w_dbz) begin
                r_quot <= '1;
                r_rem  <= bus.Dividend;
            end
        end else if (w_commit) begin
            r_quot <= w_q_sub;
            r_rem  <= w_a_sub[WIDTH-1:0];
        end
    end

    assign bus.Quotient  = r_quot;
    assign bus.Remainder = r_rem;
    assign bus.DivByZero = r_dbz;
    assign bus.Busy      = w_busy;
    assign bus.Done      = w_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_divider
//  Purpose  : Self-checking bench for seq_divider (WIDTH=8): directed cases
//             with literal expectations plus randomized operations compared
//             every cycle against a timing/arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    localparam int W = 8;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an operation is a timer of 2*W+1 edges counted from
    // the load edge, with the answer given by plain / and %.
    bit         m_active = 1'b0;
    bit         m_done   = 1'b0;
    int         m_k      = 0;
    logic [7:0] m_q      = '0;
    logic [7:0] m_r      = '0;
    logic [7:0] m_pq     = '0;
    logic [7:0] m_pr     = '0;
    bit         m_dbz    = 1'b0;

    // Model advances on the same edges as the DUT.
    always @(posedge Clk) begin
        if (Reset) begin
            m_active = 0; m_done = 0; m_k = 0;
            m_q = 0; m_r = 0; m_dbz = 0;
        end else if (m_active) begin
            m_k++;
            if (m_k == 2 * W + 1) begin
                m_active = 0;
                m_done   = 1;
                m_q      = m_pq;
                m_r      = m_pr;
            end
        end else if (m_done) begin
            if (!bus.Run) m_done = 0;
        end else if (bus.Run) begin
            if (bus.Divisor == 0) begin
                m_done = 1;
                m_dbz  = 1;
                m_q    = 8'hFF;
                m_r    = bus.Dividend;
            end else begin
                m_active = 1;
                m_k      = 1;
                m_dbz    = 0;
                m_pq     = bus.Dividend / bus.Divisor;
                m_pr     = bus.Dividend % bus.Divisor;
            end
        end
    end

    // Compare every observable output against the model, mid-cycle.
    always @(negedge Clk) begin
        if (chk_en) begin
            check("busy",      bus.Busy,      m_active);
            check("done",      bus.Done,      m_done);
            check("quotient",  bus.Quotient,  m_q);
            check("remainder", bus.Remainder, m_r);
            check("divbyzero", bus.DivByZero, m_dbz);
        end
    end

    // Start an operation and return at the negedge where Done is visible.
    // lat counts edges with the load edge as edge 1.
    task automatic do_op(input logic [7:0] dd, input logic [7:0] dv,
                         input bit scramble, output int lat);
        @(negedge Clk);
        bus.Dividend = dd;
        bus.Divisor  = dv;
        bus.Run      = 1'b1;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clk);
            lat++;
            @(negedge Clk);
            if (bus.Done) break;
            if (scramble) begin
                bus.Dividend = 8'($urandom);
                bus.Divisor  = 8'($urandom);
                bus.Run      = 1'($urandom);
            end
        end
        check("done_reached", bus.Done, 1);
    endtask

    task automatic release_run();
        bus.Run = 1'b0;
        @(negedge Clk);
    endtask

    int         lat;
    logic [7:0] r_dd;
    logic [7:0] r_dv;
    logic [7:0] tbl_dd [3] = '{8'd255, 8'd5, 8'd255};
    logic [7:0] tbl_dv [3] = '{8'd1,   8'd9, 8'd255};
    logic [7:0] tbl_q  [3] = '{8'd255, 8'd0, 8'd1};
    logic [7:0] tbl_r  [3] = '{8'd0,   8'd5, 8'd0};

    initial begin
        Reset        = 1'b1;
        bus.Run      = 1'b0;
        bus.Dividend = '0;
        bus.Divisor  = '0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk_en = 1'b1;
        check("rst_busy", bus.Busy, 0);
        check("rst_done", bus.Done, 0);
        check("rst_quot", bus.Quotient, 0);
        check("rst_rem",  bus.Remainder, 0);
        check("rst_dbz",  bus.DivByZero, 0);
        Reset = 1'b0;

        // 100 / 7
        do_op(8'd100, 8'd7, 1'b0, lat);
        check("lat_100_7", lat, 17);
        check("q_100_7", bus.Quotient, 14);
        check("r_100_7", bus.Remainder, 2);
        check("dbz_100_7", bus.DivByZero, 0);
        release_run();

        // Boundary operand pairs
        for (int i = 0; i < 3; i++) begin
            do_op(tbl_dd[i], tbl_dv[i], 1'b0, lat);
            check("lat_tbl", lat, 17);
            check("q_tbl", bus.Quotient, tbl_q[i]);
            check("r_tbl", bus.Remainder, tbl_r[i]);
            release_run();
        end

        // Divide by zero, result held through IDLE, cleared by next load
        do_op(8'd42, 8'd0, 1'b0, lat);
        check("lat_dbz", lat, 1);
        check("dbz_set", bus.DivByZero, 1);
        check("q_dbz", bus.Quotient, 8'hFF);
        check("r_dbz", bus.Remainder, 42);
        release_run();
        check("q_hold_idle", bus.Quotient, 8'hFF);
        check("busy_idle", bus.Busy, 0);
        do_op(8'd100, 8'd7, 1'b0, lat);
        check("dbz_cleared", bus.DivByZero, 0);
        check("q_after_dbz", bus.Quotient, 14);
        release_run();

        // Reset landing on edge 6 of 100/7
        @(negedge Clk);
        bus.Dividend = 8'd100;
        bus.Divisor  = 8'd7;
        bus.Run      = 1'b1;
        repeat (5) @(negedge Clk);
        check("busy_before_abort", bus.Busy, 1);
        Reset   = 1'b1;
        bus.Run = 1'b0;
        @(negedge Clk);
        check("abort_busy", bus.Busy, 0);
        check("abort_done", bus.Done, 0);
        check("abort_quot", bus.Quotient, 0);
        check("abort_rem",  bus.Remainder, 0);
        Reset = 1'b0;
        do_op(8'd200, 8'd3, 1'b0, lat);
        check("lat_200_3", lat, 17);
        check("q_200_3", bus.Quotient, 66);
        check("r_200_3", bus.Remainder, 2);

        // Run still high from 200/3: no retrigger for 10 cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            check("hold_done", bus.Done, 1);
            check("hold_busy", bus.Busy, 0);
            check("hold_quot", bus.Quotient, 66);
        end
        release_run();
        do_op(8'd9, 8'd4, 1'b0, lat);
        check("q_9_4", bus.Quotient, 2);
        check("r_9_4", bus.Remainder, 1);
        release_run();

        // Operands and Run scrambled while busy
        do_op(8'd100, 8'd7, 1'b1, lat);
        check("lat_scr", lat, 17);
        check("q_scr", bus.Quotient, 14);
        check("r_scr", bus.Remainder, 2);
        release_run();

        // Random operations
        for (int n = 0; n < 1000; n++) begin
            int sel;
            r_dd = 8'($urandom_range(0, 255));
            sel  = int'($urandom_range(0, 9));
            if (sel == 0)      r_dv = 8'd0;
            else if (sel == 1) r_dv = 8'd1;
            else if (sel == 2) r_dv = r_dd;
            else               r_dv = 8'($urandom_range(1, 255));
            do_op(r_dd, r_dv, 1'($urandom), lat);
            check("lat_rand", lat, (r_dv == 0) ? 1 : 17);
            release_run();
            repeat ($urandom_range(0, 2)) @(negedge Clk);
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
